// File: rtl/round_const_pkg.sv
// Shared state type and GF(2^8) xtime helpers for the round-constant
// sequencer.
package round_const_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [7:0] RC_POLY_DEFAULT = 8'h1b;

    function automatic logic [7:0] rc_fwd(
        input logic [7:0] x,
        input logic [7:0] poly
    );
        return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
    endfunction

    // Undo xtime: an odd value can only come from a reduced product.
    function automatic logic [7:0] rc_inv(
        input logic [7:0] y,
        input logic [7:0] poly
    );
        logic [7:0] t;
        t = y ^ poly;
        return y[0] ? {1'b1, t[7:1]} : {1'b0, y[7:1]};
    endfunction

endpackage

// File: rtl/gf_xtime_step.sv
// One step of the round-constant walk: multiply or divide by x in
// GF(2^8).
module gf_xtime_step
    import round_const_pkg::*;
#(
    parameter logic [7:0] POLY = RC_POLY_DEFAULT
) (
    input  logic [7:0] x,
    input  logic       dir,
    output logic [7:0] y
);

    assign y = dir ? rc_inv(x, POLY) : rc_fwd(x, POLY);

endmodule

// File: rtl/round_const_seq.sv
// Round-constant sequencer: pops a seed, pushes NR successive xtime
// (or inverse xtime) words, chaining seeds with no idle cycle.
module round_const_seq
    import round_const_pkg::*;
#(
    parameter int         NR   = 10,
    parameter logic [7:0] POLY = RC_POLY_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_rc,
    input  logic       in_dir,
    input  logic       in_rc_empty,
    output logic       in_rc_rd,
    output logic [7:0] out_rc,
    output logic       out_last,
    output logic       out_rc_wr,
    input  logic       out_rc_full,
    output logic       busy
);

    localparam int            CW   = $clog2(NR + 1);
    localparam logic [CW-1:0] LAST = CW'(NR - 1);

    state_t        state;
    logic [7:0]    cur;
    logic [7:0]    nxt;
    logic          dir;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          final_wr;

    gf_xtime_step #(
        .POLY(POLY)
    ) u_step (
        .x  (cur),
        .dir(dir),
        .y  (nxt)
    );

    assign busy      = (state == EMIT);
    assign out_rc    = cur;
    assign out_last  = busy && (cnt == LAST);
    assign out_rc_wr = reset && busy && !out_rc_full;
    assign final_wr  = out_rc_wr && (cnt == LAST);

    // armed keeps the pop quiet in the first cycle out of reset.
    assign in_rc_rd  = reset && armed && !in_rc_empty &&
                       ((state == IDLE) || final_wr);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cur   <= 8'h00;
            dir   <= 1'b0;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (in_rc_rd) begin
                        cur   <= in_rc;
                        dir   <= in_dir;
                        cnt   <= '0;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_rc_wr) begin
                        if (cnt != LAST) begin
                            cur <= nxt;
                            cnt <= cnt + CW'(1);
                        end else if (in_rc_rd) begin
                            cur <= in_rc;
                            dir <= in_dir;
                            cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/round_const_seq.md
ROUND_CONST_SEQ -- requirements
Module: round_const_seq

Interface
REQ-001 The parameter NR SHALL be: default 10; the number of round constants emitted per seed, legal range 1..255.
REQ-002 The parameter POLY SHALL be: default 8'h1b; the GF(2^8) reduction byte, with bit 0 set.
REQ-003 The port clock SHALL be: input, 1 bit; the single clock, rising edge.
REQ-004 The port reset SHALL be: input, 1 bit; synchronous, active-low reset.
REQ-005 The port in_rc SHALL be: input, 8 bits; the seed word, valid whenever in_rc_empty=0.
REQ-006 The port in_dir SHALL be: input, 1 bit; the sequence direction, 0=forward (multiply by x), 1=inverse (divide by x); qualified with in_rc.
REQ-007 The port in_rc_empty SHALL be: input, 1 bit; the input FIFO empty flag.
REQ-008 The port in_rc_rd SHALL be: output, 1 bit; the input FIFO pop, one pulse per seed consumed.
REQ-009 The port out_rc SHALL be: output, 8 bits; the round constant.
REQ-010 The port out_last SHALL be: output, 1 bit; high with the NR-th word of a sequence.
REQ-011 The port out_rc_wr SHALL be: output, 1 bit; the output FIFO push.
REQ-012 The port out_rc_full SHALL be: input, 1 bit; the output FIFO full flag.
REQ-013 The port busy SHALL be: output, 1 bit; high while a sequence is in progress.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and EMIT.
REQ-015 In IDLE with in_rc_empty=0, the block SHALL assert in_rc_rd combinationally in that cycle, latch in_rc into cur and in_dir into dir, clear cnt, and go to EMIT.
REQ-016 In IDLE with in_rc_empty=1, in_rc_rd SHALL be 0 and the state SHALL hold.
REQ-017 out_rc SHALL be driven from the cur register, and out_last SHALL equal (state==EMIT && cnt==NR-1).
REQ-018 out_rc_wr SHALL equal (state==EMIT && out_rc_full==0).
REQ-019 On each write, cur SHALL be updated to F(cur) when dir=0, or to Finv(cur) when dir=1, and cnt SHALL increment.
REQ-020 F(x) SHALL equal (x<<1) ^ (x[7] ? POLY : 0), truncated to 8 bits.
REQ-021 Finv(y) SHALL equal y[0] ? (((y ^ POLY)>>1) | 8'h80) : (y>>1), so that Finv(F(x)) = x for all 256 values of x.
REQ-022 While out_rc_full=1 in EMIT, there SHALL be no write, and cur, cnt and out_rc SHALL hold stable.
REQ-023 On the write with cnt==NR-1 the sequence SHALL end; if in_rc_empty=0 in that same cycle, in_rc_rd SHALL assert and the next seed SHALL load with the state staying EMIT (zero bubble); otherwise the state SHALL go to IDLE.
REQ-024 in_rc_rd SHALL never assert in EMIT except on a final write.
REQ-025 Latency SHALL be: a seed read in cycle t gives its first write at the earliest in cycle t+1.
REQ-026 Sustained throughput SHALL be one word per cycle when out_rc_full=0.
REQ-027 busy SHALL equal (state==EMIT).
REQ-028 With NR=1 the block SHALL emit only the seed, with out_last=1.
REQ-029 The cnt width SHALL be $clog2(NR+1) bits, and cnt SHALL never wrap within a sequence.

Reset
REQ-030 While reset=0 at a clock edge, the state SHALL become IDLE, and cur, cnt and dir SHALL be set to 0.
REQ-031 During reset and in the first cycle after reset, out_rc SHALL be 0, out_last 0, busy 0, in_rc_rd 0 and out_rc_wr 0.
REQ-032 A reset applied mid-sequence SHALL abandon the remaining words without any further write, and the consumed seed SHALL be lost.

Structure
REQ-033 The package round_const_pkg SHALL hold: the state enum {IDLE, EMIT}, the RC_POLY_DEFAULT=8'h1b constant, and the automatic functions rc_fwd(x,poly) and rc_inv(y,poly).
REQ-034 A single combinational sub-module, gf_xtime_step (inputs x, dir; output y; parameter POLY), SHALL compute the next cur value.
REQ-035 All other logic SHALL reside in round_const_seq.

Verification
REQ-036 Forward test: NR=10, seed 8'h01, dir=0, full=0 -> the block SHALL emit 01,02,04,08,10,20,40,80,1b,36 on consecutive cycles, with out_last only on 36.
REQ-037 Inverse test: seed 8'h36, dir=1 -> the block SHALL emit 36,1b,80,40,20,10,08,04,02,01, with out_last on 01.
REQ-038 Stall test: out_rc_full=1 for 3 cycles while out_rc=8'h08 -> out_rc_wr SHALL be 0 and out_rc SHALL hold 08; after release the block SHALL resume with 08 then 10, with no word lost or duplicated.
REQ-039 Back-to-back test: two seeds queued (01 fwd, 36 inv) -> the block SHALL produce 20 writes on 20 consecutive cycles, with in_rc_rd pulsing in the same cycle as the first out_last.
REQ-040 Reset test: reset=0 applied after the 4th write -> the next cycle SHALL show out_rc_wr=0, busy=0 and out_rc=0, and after release the next seed SHALL restart cleanly from cnt=0.
REQ-041 Exhaustive check: for all 256 x values and POLY=8'h1b, gf_xtime_step with dir=1 applied to the dir=0 result SHALL return x.
